// File: rtl/sd_sektor_strom_pkg.sv
// ---------------------------------------------------------------------------
// sd_sektor_strom_pkg : block geometry, address defaults and FSM states
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package sd_sektor_strom_pkg;

    localparam int BLOCK_BITS        = 4096;
    localparam int WORT_BITS         = 32;
    localparam int WOERTER_PRO_BLOCK = BLOCK_BITS / WORT_BITS;
    localparam int IDX_BITS          = $clog2(WOERTER_PRO_BLOCK);
    localparam int ADR_SHIFT_DEF     = 9;
    localparam int SEKTOR_BITS_DEF   = 23;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ANFRAGE = 3'd1,
        S_WARTEN  = 3'd2,
        S_AUSGABE = 3'd3,
        S_ENDE    = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/sd_sektor_strom_block_serialisierer.sv
// ---------------------------------------------------------------------------
// sd_block_serialisierer : 4096-bit block buffer streamed MSB-first as words
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sd_block_serialisierer
    import sd_sektor_strom_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load_i,
    input  logic [BLOCK_BITS-1:0] daten_i,
    input  logic                  bereit_i,
    output logic [WORT_BITS-1:0]  wort_o,
    output logic                  gueltig_o,
    output logic                  word_accepted_o,
    output logic                  last_word_o
);

    logic [BLOCK_BITS-1:0] puffer_q, puffer_d;
    logic [IDX_BITS-1:0]   idx_q, idx_d;
    logic                  gueltig_q, gueltig_d;

    assign wort_o          = puffer_q[BLOCK_BITS-1 -: WORT_BITS];
    assign gueltig_o       = gueltig_q;
    assign word_accepted_o = gueltig_q && bereit_i;
    assign last_word_o     = (idx_q == IDX_BITS'(WOERTER_PRO_BLOCK - 1));

    always_comb begin
        puffer_d  = puffer_q;
        idx_d     = idx_q;
        gueltig_d = gueltig_q;
        if (load_i) begin
            puffer_d  = daten_i;
            idx_d     = '0;
            gueltig_d = 1'b1;
        end else if (word_accepted_o) begin
            // Shifting in zeros leaves Wort at 0 once the block is drained.
            puffer_d  = {puffer_q[BLOCK_BITS-WORT_BITS-1:0], {WORT_BITS{1'b0}}};
            idx_d     = idx_q + 1'b1;
            if (last_word_o) begin
                gueltig_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            puffer_q  <= '0;
            idx_q     <= '0;
            gueltig_q <= 1'b0;
        end else begin
            puffer_q  <= puffer_d;
            idx_q     <= idx_d;
            gueltig_q <= gueltig_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/sd_sektor_strom.sv
// ---------------------------------------------------------------------------
// sd_sektor_strom : reads consecutive SD sectors and streams them as words
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sd_sektor_strom
    import sd_sektor_strom_pkg::*;
#(
    parameter int ADR_SHIFT   = ADR_SHIFT_DEF,
    parameter int SEKTOR_BITS = SEKTOR_BITS_DEF
) (
    input  logic                   Clock_i,
    input  logic                   Reset_i,
    input  logic                   Start_i,
    input  logic [SEKTOR_BITS-1:0] StartSektor_i,
    input  logic [15:0]            Anzahl_i,
    output logic                   Aktiv_o,
    output logic                   Fertig_o,
    output logic [WORT_BITS-1:0]   Wort_o,
    output logic                   WortGueltig_o,
    input  logic                   WortBereit_i,
    output logic [31:0]            SdAdresse_o,
    output logic                   SdLesen_o,
    input  logic [BLOCK_BITS-1:0]  SdDaten_i,
    input  logic                   SdFertig_i,
    input  logic                   SdBusy_i
);

    state_t                   state_q, state_d;
    logic [SEKTOR_BITS-1:0]   sektor_q, sektor_d, sektor_plus;
    logic [15:0]              rest_q, rest_d;
    logic [31:0]              adr_q, adr_d;
    logic                     lesen_q, lesen_d;
    logic                     fertig_q, fertig_d;
    logic                     laden;
    logic                     wort_acc, letztes_wort;

    assign sektor_plus   = sektor_q + SEKTOR_BITS'(1);
    assign Aktiv_o       = (state_q != S_IDLE) || fertig_q;
    assign Fertig_o      = fertig_q;
    assign SdAdresse_o   = adr_q;
    assign SdLesen_o     = lesen_q;

    sd_block_serialisierer u_ser (
        .clk_i           (Clock_i),
        .rst_i           (Reset_i),
        .load_i          (laden),
        .daten_i         (SdDaten_i),
        .bereit_i        (WortBereit_i),
        .wort_o          (Wort_o),
        .gueltig_o       (WortGueltig_o),
        .word_accepted_o (wort_acc),
        .last_word_o     (letztes_wort)
    );

    always_comb begin
        state_d  = state_q;
        sektor_d = sektor_q;
        rest_d   = rest_q;
        adr_d    = adr_q;
        lesen_d  = lesen_q;
        fertig_d = 1'b0;
        laden    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Start_i) begin
                    if (Anzahl_i != 16'd0) begin
                        sektor_d = StartSektor_i;
                        rest_d   = Anzahl_i;
                        adr_d    = {StartSektor_i, {ADR_SHIFT{1'b0}}};
                        lesen_d  = 1'b1;
                        state_d  = S_ANFRAGE;
                    end else begin
                        fertig_d = 1'b1;
                    end
                end
            end
            // Leaving only after Busy is seen means any stale SdFertig is never taken as this block.
            S_ANFRAGE: begin
                if (SdBusy_i) begin
                    lesen_d = 1'b0;
                    state_d = S_WARTEN;
                end
            end
            S_WARTEN: begin
                if (SdFertig_i) begin
                    laden   = 1'b1;
                    state_d = S_AUSGABE;
                end
            end
            S_AUSGABE: begin
                if (wort_acc && letztes_wort) begin
                    rest_d   = rest_q - 16'd1;
                    sektor_d = sektor_plus;
                    if (rest_q != 16'd1) begin
                        adr_d   = {sektor_plus, {ADR_SHIFT{1'b0}}};
                        lesen_d = 1'b1;
                        state_d = S_ANFRAGE;
                    end else begin
                        fertig_d = 1'b1;
                        state_d  = S_ENDE;
                    end
                end
            end
            S_ENDE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock_i) begin
        if (Reset_i) begin
            state_q  <= S_IDLE;
            sektor_q <= '0;
            rest_q   <= '0;
            adr_q    <= '0;
            lesen_q  <= 1'b0;
            fertig_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sektor_q <= sektor_d;
            rest_q   <= rest_d;
            adr_q    <= adr_d;
            lesen_q  <= lesen_d;
            fertig_q <= fertig_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sd_sektor_strom.sv
// ---------------------------------------------------------------------------
// tb_sd_sektor_strom : directed bench with a behavioural SDKarte model
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sd_sektor_strom;

    localparam int SD_LATENZ = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [22:0]   start_sektor;
    logic [15:0]   anzahl;
    logic          aktiv, fertig, gueltig, bereit;
    logic [31:0]   wort, sd_adr;
    logic          sd_lesen;
    logic [4095:0] sd_daten = '0;
    logic          sd_fertig = 1'b0;
    logic          sd_busy = 1'b0;

    int total = 0;
    int bad   = 0;

    int          req_n = 0;
    logic [22:0] req_sek [0:31];
    logic [31:0] req_adr [0:31];
    logic [22:0] mod_sek = '0;
    int          mod_cnt = 0;

    always #5 clk = ~clk;

    sd_sektor_strom dut (
        .Clock_i       (clk),
        .Reset_i       (rst),
        .Start_i       (start),
        .StartSektor_i (start_sektor),
        .Anzahl_i      (anzahl),
        .Aktiv_o       (aktiv),
        .Fertig_o      (fertig),
        .Wort_o        (wort),
        .WortGueltig_o (gueltig),
        .WortBereit_i  (bereit),
        .SdAdresse_o   (sd_adr),
        .SdLesen_o     (sd_lesen),
        .SdDaten_i     (sd_daten),
        .SdFertig_i    (sd_fertig),
        .SdBusy_i      (sd_busy)
    );

    function automatic logic [4095:0] muster(input logic [22:0] s);
        logic [4095:0] m;
        m = '0;
        for (int i = 0; i < 128; i++) begin
            m[4095 - 32*i -: 32] = {s[15:0], 16'(i)};
        end
        return m;
    endfunction

    // SDKarte model: Busy one cycle after Lesen, Fertig pulse SD_LATENZ+1 cycles later.
    always @(posedge clk) begin
        if (rst) begin
            sd_busy   <= 1'b0;
            sd_fertig <= 1'b0;
            mod_cnt   <= 0;
        end else begin
            sd_fertig <= 1'b0;
            if (sd_busy) begin
                if (mod_cnt == 0) begin
                    sd_busy   <= 1'b0;
                    sd_fertig <= 1'b1;
                    sd_daten  <= muster(mod_sek);
                end else begin
                    mod_cnt <= mod_cnt - 1;
                end
            end else if (sd_lesen) begin
                sd_busy <= 1'b1;
                mod_cnt <= SD_LATENZ;
                mod_sek <= sd_adr[31:9];
                if (req_n < 32) begin
                    req_sek[req_n] <= sd_adr[31:9];
                    req_adr[req_n] <= sd_adr;
                end
                req_n <= req_n + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic takt();
        @(posedge clk);
        #1;
    endtask

    task automatic kommando(input logic [22:0] s, input logic [15:0] a);
        start_sektor = s;
        anzahl       = a;
        start        = 1'b1;
        takt();
        start        = 1'b0;
    endtask

    task automatic pruefe_reset_werte(input string tag);
        chk({tag, "_aktiv"},   64'(aktiv),    64'd0);
        chk({tag, "_fertig"},  64'(fertig),   64'd0);
        chk({tag, "_gueltig"}, 64'(gueltig),  64'd0);
        chk({tag, "_lesen"},   64'(sd_lesen), 64'd0);
        chk({tag, "_wort"},    64'(wort),     64'd0);
        chk({tag, "_adr"},     64'(sd_adr),   64'd0);
    endtask

    // mode 0: always ready; 1: random ready with a 10-cycle stall at word 64;
    // 2: always ready, plus a stray Start pulse at word 200.
    task automatic strom(input string tag, input logic [22:0] sek, input int anz, input int mode);
        int          w = 0;
        int          zyklen = 0;
        int          stall_cnt = 0;
        int          fert = 0;
        logic        prev_stall = 1'b0;
        logic [31:0] prev_wort = '0;
        logic [22:0] cur = sek;
        logic        r;
        while (fert == 0 && zyklen < 20000) begin
            takt();
            zyklen++;
            start = 1'b0;
            if (prev_stall) begin
                chk({tag, "_stall"}, {31'd0, gueltig, wort}, {31'd0, 1'b1, prev_wort});
            end
            if (fertig) begin
                fert++;
                chk({tag, "_woerter_bei_fertig"}, 64'(w), 64'(anz * 128));
            end
            if (mode == 1) begin
                if (w == 64 && stall_cnt < 10) begin
                    r = 1'b0;
                    stall_cnt++;
                end else begin
                    r = 1'($urandom_range(0, 1));
                end
            end else begin
                r = 1'b1;
            end
            if (mode == 2 && w == 200 && gueltig) begin
                start_sektor = 23'h55;
                anzahl       = 16'd7;
                start        = 1'b1;
            end
            bereit     = r;
            prev_stall = gueltig && !r;
            prev_wort  = wort;
            if (gueltig && r) begin
                chk({tag, "_wort"}, 64'(wort), 64'({cur[15:0], 16'(w % 128)}));
                w++;
                if (w % 128 == 0) cur = cur + 23'd1;
            end
        end
        start = 1'b0;
        chk({tag, "_fertig_gesehen"}, 64'(fert), 64'd1);
        chk({tag, "_woerter"}, 64'(w), 64'(anz * 128));
        takt();
        chk({tag, "_fertig_puls"}, 64'(fertig), 64'd0);
        chk({tag, "_aktiv_aus"}, 64'(aktiv), 64'd0);
    endtask

    initial begin
        int n0;
        rst          = 1'b1;
        start        = 1'b0;
        start_sektor = '0;
        anzahl       = '0;
        bereit       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        pruefe_reset_werte("reset");
        rst = 1'b0;
        takt();

        // Single sector 5
        n0 = req_n;
        kommando(23'd5, 16'd1);
        chk("t1_aktiv", 64'(aktiv), 64'd1);
        chk("t1_lesen", 64'(sd_lesen), 64'd1);
        chk("t1_adr", 64'(sd_adr), 64'h0000_0A00);
        strom("t1", 23'd5, 1, 0);
        chk("t1_anfragen", 64'(req_n - n0), 64'd1);
        chk("t1_req_adr", 64'(req_adr[n0]), 64'h0000_0A00);

        // Three sectors across the 2^23 wrap
        n0 = req_n;
        kommando(23'h7FFFFF, 16'd3);
        chk("t2_adr", 64'(sd_adr), 64'hFFFF_FE00);
        strom("t2", 23'h7FFFFF, 3, 0);
        chk("t2_anfragen", 64'(req_n - n0), 64'd3);
        chk("t2_sek0", 64'(req_sek[n0]),     64'h7FFFFF);
        chk("t2_sek1", 64'(req_sek[n0 + 1]), 64'h000000);
        chk("t2_sek2", 64'(req_sek[n0 + 2]), 64'h000001);

        // Random backpressure with a long stall
        kommando(23'h1234, 16'd1);
        strom("t3", 23'h1234, 1, 1);

        // Zero-length request
        n0 = req_n;
        kommando(23'h33, 16'd0);
        chk("t4_fertig", 64'(fertig), 64'd1);
        chk("t4_aktiv", 64'(aktiv), 64'd1);
        chk("t4_gueltig", 64'(gueltig), 64'd0);
        chk("t4_lesen", 64'(sd_lesen), 64'd0);
        takt();
        chk("t4_fertig_aus", 64'(fertig), 64'd0);
        chk("t4_aktiv_aus", 64'(aktiv), 64'd0);
        chk("t4_anfragen", 64'(req_n - n0), 64'd0);

        // Stray Start mid-stream
        n0 = req_n;
        kommando(23'h40, 16'd2);
        strom("t5", 23'h40, 2, 2);
        chk("t5_anfragen", 64'(req_n - n0), 64'd2);
        chk("t5_sek1", 64'(req_sek[n0 + 1]), 64'h41);

        // Reset while waiting for the card
        kommando(23'd7, 16'd1);
        for (int k = 0; k < 40 && !sd_busy; k++) takt();
        chk("t6_busy_erreicht", 64'(sd_busy), 64'd1);
        takt();
        chk("t6_warten_lesen", 64'(sd_lesen), 64'd0);
        rst = 1'b1;
        takt();
        pruefe_reset_werte("t6_warten");
        rst = 1'b0;
        kommando(23'd8, 16'd1);
        strom("t6a", 23'd8, 1, 0);

        // Reset while a word is being offered
        bereit = 1'b0;
        kommando(23'd9, 16'd1);
        for (int k = 0; k < 40 && !gueltig; k++) takt();
        chk("t6_gueltig_erreicht", 64'(gueltig), 64'd1);
        chk("t6_erstes_wort", 64'(wort), 64'h0009_0000);
        rst = 1'b1;
        takt();
        pruefe_reset_werte("t6_ausgabe");
        rst = 1'b0;
        kommando(23'd10, 16'd1);
        strom("t6b", 23'd10, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
